// File: rtl/noc_input_port_buffer.sv
// rtl/noc_input_port_buffer.sv - NoC router input-port FIFO with XY route lookup and credit return
module noc_input_port_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flit_valid_i,
    input  logic [DATA_W-1:0]          flit_data_i,
    input  logic                       grant_i,
    output logic [2:0]                 nexthop_addr_o,
    output logic [DATA_W-1:0]          flit_data_o,
    output logic                       credit_return_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [X_W-1:0]   MY_X_C  = X_W'(MY_X);
    localparam logic [Y_W-1:0]   MY_Y_C  = Y_W'(MY_Y);

    localparam logic [2:0] DIR_N    = 3'b000;
    localparam logic [2:0] DIR_S    = 3'b001;
    localparam logic [2:0] DIR_W    = 3'b010;
    localparam logic [2:0] DIR_E    = 3'b011;
    localparam logic [2:0] DIR_L    = 3'b100;
    localparam logic [2:0] DIR_NONE = 3'b111;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic              push;
    logic              pop;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;

    // Push/pop decisions and next-state for pointers, occupancy, credit and overflow
    always_comb begin
        empty      = (count_q == '0);
        pop        = grant_i && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept
        push       = flit_valid_i && ((count_q < CNT_MAX) || pop);
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        credit_d   = pop;
        overflow_d = overflow_q || (flit_valid_i && !push);
    end

    // Control state; reset drops all queued flits without issuing credits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Flit storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flit_data_i;
        end
    end

    // Head presentation and XY route: resolve X first, then Y, else local
    always_comb begin
        head   = mem_q[rd_ptr_q];
        dest_x = head[X_W-1:0];
        dest_y = head[X_W+Y_W-1:X_W];
        if (empty) begin
            flit_data_o    = '0;
            nexthop_addr_o = DIR_NONE;
        end else begin
            flit_data_o = head;
            if (dest_x > MY_X_C) begin
                nexthop_addr_o = DIR_E;
            end else if (dest_x < MY_X_C) begin
                nexthop_addr_o = DIR_W;
            end else if (dest_y > MY_Y_C) begin
                nexthop_addr_o = DIR_S;
            end else if (dest_y < MY_Y_C) begin
                nexthop_addr_o = DIR_N;
            end else begin
                nexthop_addr_o = DIR_L;
            end
        end
    end

    assign credit_return_o = credit_q;
    assign count_o         = count_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_noc_input_port_buffer.sv
// tb/tb_noc_input_port_buffer.sv - directed self-checking bench for noc_input_port_buffer
module tb_noc_input_port_buffer;

    logic        clk;
    logic        reset;
    logic        flit_valid_i;
    logic [31:0] flit_data_i;
    logic        grant_i;
    logic [2:0]  nexthop_addr_o;
    logic [31:0] flit_data_o;
    logic        credit_return_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int n_tests;
    int n_fail;

    noc_input_port_buffer #(
        .DATA_W(32), .DEPTH(4), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flit_valid_i   (flit_valid_i),
        .flit_data_i    (flit_data_i),
        .grant_i        (grant_i),
        .nexthop_addr_o (nexthop_addr_o),
        .flit_data_o    (flit_data_o),
        .credit_return_o(credit_return_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one active edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_flit(input int x, input int y, input int tag);
        logic [31:0] f;
        f = (32'(tag) << 4) | (32'(y & 3) << 2) | 32'(x & 3);
        return f;
    endfunction

    task automatic apply_reset();
        flit_valid_i = 1'b0;
        grant_i      = 1'b0;
        #2;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        flit_valid_i = 1'b0;
        flit_data_i  = '0;
        grant_i      = 1'b0;
        #12;
        n_tests++;
        if (nexthop_addr_o !== 3'b111) begin
            n_fail++; $display("FAIL reset_nexthop got=%b exp=111", nexthop_addr_o);
        end
        n_tests++;
        if (count_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o);
        end
        n_tests++;
        if (credit_return_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_credit got=%b exp=0", credit_return_o);
        end
        n_tests++;
        if (overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow_o);
        end
        n_tests++;
        if (flit_data_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_data got=%h exp=0", flit_data_o);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_routing();
        int          xs [5] = '{3, 0, 1, 1, 1};
        int          ys [5] = '{1, 1, 3, 0, 1};
        logic [2:0]  exp_dir [5] = '{3'b011, 3'b010, 3'b001, 3'b000, 3'b100};
        logic [31:0] f;
        int          credits;
        credits = 0;
        for (int i = 0; i < 5; i++) begin
            f = mk_flit(xs[i], ys[i], i + 1);
            flit_valid_i = 1'b1;
            flit_data_i  = f;
            step();
            flit_valid_i = 1'b0;
            n_tests++;
            if (nexthop_addr_o !== exp_dir[i] || flit_data_o !== f || count_o !== 3'd1) begin
                n_fail++;
                $display("FAIL route_%0d got dir=%b data=%h cnt=%0d exp dir=%b data=%h cnt=1",
                         i, nexthop_addr_o, flit_data_o, count_o, exp_dir[i], f);
            end
            grant_i = 1'b1;
            step();
            grant_i = 1'b0;
            if (credit_return_o === 1'b1) credits++;
            n_tests++;
            if (credit_return_o !== 1'b1 || count_o !== 3'd0 || nexthop_addr_o !== 3'b111) begin
                n_fail++;
                $display("FAIL route_pop_%0d got credit=%b cnt=%0d dir=%b exp credit=1 cnt=0 dir=111",
                         i, credit_return_o, count_o, nexthop_addr_o);
            end
            step();
            n_tests++;
            if (credit_return_o !== 1'b0) begin
                n_fail++; $display("FAIL route_credit_width_%0d got=%b exp=0", i, credit_return_o);
            end
        end
        n_tests++;
        if (credits != 5) begin
            n_fail++; $display("FAIL route_credit_total got=%0d exp=5", credits);
        end
    endtask

    task automatic test_fill_overflow();
        int credits;
        for (int i = 0; i < 5; i++) begin
            flit_valid_i = 1'b1;
            flit_data_i  = 32'h100 + 32'(i);
            step();
            if (i == 3) begin
                n_tests++;
                if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
                    n_fail++; $display("FAIL fill_full got cnt=%0d ovf=%b exp cnt=4 ovf=0", count_o, overflow_o);
                end
            end
        end
        flit_valid_i = 1'b0;
        n_tests++;
        if (count_o !== 3'd4 || overflow_o !== 1'b1 || flit_data_o !== 32'h100) begin
            n_fail++;
            $display("FAIL overflow_set got cnt=%0d ovf=%b head=%h exp cnt=4 ovf=1 head=00000100",
                     count_o, overflow_o, flit_data_o);
        end
        credits = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (flit_data_o !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL drain_order_%0d got=%h exp=%h", i, flit_data_o, 32'h100 + 32'(i));
            end
            grant_i = 1'b1;
            step();
            if (credit_return_o === 1'b1) credits++;
        end
        grant_i = 1'b0;
        step();
        n_tests++;
        if (credits != 4 || credit_return_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_credits got=%0d last=%b exp=4 last=0", credits, credit_return_o);
        end
        n_tests++;
        if (count_o !== 3'd0 || nexthop_addr_o !== 3'b111 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end got cnt=%0d dir=%b ovf=%b exp cnt=0 dir=111 ovf=1",
                     count_o, nexthop_addr_o, overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        n_tests++;
        if (overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_cleared got=%b exp=0", overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            flit_valid_i = 1'b1;
            flit_data_i  = 32'h200 + 32'(i);
            step();
        end
        flit_data_i = 32'h204;
        grant_i     = 1'b1;
        step();
        flit_valid_i = 1'b0;
        grant_i      = 1'b0;
        n_tests++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0 || credit_return_o !== 1'b1 || flit_data_o !== 32'h201) begin
            n_fail++;
            $display("FAIL full_pushpop got cnt=%0d ovf=%b credit=%b head=%h exp cnt=4 ovf=0 credit=1 head=00000201",
                     count_o, overflow_o, credit_return_o, flit_data_o);
        end
        for (int i = 1; i < 5; i++) begin
            n_tests++;
            if (flit_data_o !== 32'h200 + 32'(i)) begin
                n_fail++; $display("FAIL full_tail_%0d got=%h exp=%h", i, flit_data_o, 32'h200 + 32'(i));
            end
            grant_i = 1'b1;
            step();
        end
        grant_i = 1'b0;
        step();
        n_tests++;
        if (count_o !== 3'd0) begin
            n_fail++; $display("FAIL full_drained got=%0d exp=0", count_o);
        end
    endtask

    task automatic test_wrap();
        int credits;
        credits = 0;
        for (int i = 0; i < 10; i++) begin
            flit_valid_i = 1'b1;
            flit_data_i  = 32'h10 + 32'(i);
            step();
            flit_valid_i = 1'b0;
            n_tests++;
            if (flit_data_o !== 32'h10 + 32'(i)) begin
                n_fail++; $display("FAIL wrap_data_%0d got=%h exp=%h", i, flit_data_o, 32'h10 + 32'(i));
            end
            grant_i = 1'b1;
            step();
            grant_i = 1'b0;
            if (credit_return_o === 1'b1) credits++;
        end
        n_tests++;
        if (credits != 10) begin
            n_fail++; $display("FAIL wrap_credits got=%0d exp=10", credits);
        end
        grant_i = 1'b1;
        step();
        step();
        grant_i = 1'b0;
        n_tests++;
        if (credit_return_o !== 1'b0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL empty_grant got credit=%b cnt=%0d exp credit=0 cnt=0", credit_return_o, count_o);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            flit_valid_i = 1'b1;
            flit_data_i  = mk_flit(3, 3, i);
            step();
        end
        flit_valid_i = 1'b0;
        n_tests++;
        if (count_o !== 3'd3) begin
            n_fail++; $display("FAIL midrst_pre got=%0d exp=3", count_o);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (count_o !== 3'd0 || nexthop_addr_o !== 3'b111 || credit_return_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async got cnt=%0d dir=%b credit=%b exp cnt=0 dir=111 credit=0",
                     count_o, nexthop_addr_o, credit_return_o);
        end
        #1;
        reset = 1'b1;
        step();
        n_tests++;
        if (count_o !== 3'd0 || credit_return_o !== 1'b0 || flit_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_after got cnt=%0d credit=%b data=%h exp cnt=0 credit=0 data=0",
                     count_o, credit_return_o, flit_data_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_routing();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
